// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch stage.
//   ADDR_W_D / INSTR_W_D : default PC width and instruction width
//   PC_STEP_D            : default PC increment per fetched instruction
//   fetch_entry_t        : one queue entry {pc, instr} at the default widths
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W_D  = 12;
  localparam int INSTR_W_D = 32;
  localparam int PC_STEP_D = 4;

  // The queue stores the PC in the upper bits and the instruction in the
  // lower bits, so this struct's field order matches the packed storage word.
  typedef struct packed {
    logic [ADDR_W_D-1:0]  pc;
    logic [INSTR_W_D-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Generic DEPTH x WIDTH circular buffer with synchronous flush.
//   clk, rst  : clock, asynchronous active-high reset
//   i_enq     : write i_data at the tail (accepted when not full, or when a
//               dequeue happens in the same cycle)
//   i_deq     : pop the head (ignored when empty)
//   i_flush   : empty the buffer; overrides enq and deq
//   i_data    : write data
//   o_data    : head entry (registered storage)
//   o_count   : number of occupied entries
//   o_full    : o_count == DEPTH
//   o_empty   : o_count == 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enq,
  input  logic                     i_deq,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic w_do_deq;
  logic w_do_enq;

  assign o_count = r_count;
  assign o_full  = (r_count == (IDX_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_head];

  // When full, tail == head; a simultaneous pop frees the slot that the
  // push overwrites, and the read of the old head happens before the edge.
  assign w_do_deq = i_deq & ~i_flush & ~o_empty;
  assign w_do_enq = i_enq & ~i_flush & (~o_full | w_do_deq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (w_do_enq) r_tail <= r_tail + IDX_W'(1);
      if (w_do_deq) r_head <= r_head + IDX_W'(1);
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + (IDX_W+1)'(1);
        2'b01:   r_count <= r_count - (IDX_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so the head output is never X afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_enq) begin
      r_mem[r_tail] <= i_data;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Fetch stage between the PC, a combinational instruction ROM and decode.
// Owns the PC, drives the ROM address and queues {pc, instr} pairs.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_addr       : ROM address (the current PC)
//   imem_data       : ROM data, combinational from imem_addr
//   redirect_valid  : flush the queue and load redirect_pc into the PC
//   redirect_pc     : new PC for a redirect
//   out_valid       : head entry valid (withheld during a redirect cycle)
//   out_pc          : PC of the head entry
//   out_instr       : instruction of the head entry
//   out_ready       : decode accepts the head this cycle
//   count           : number of occupied entries
//   full            : count == DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int INSTR_W  = INSTR_W_D,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = PC_STEP_D,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  r_pc;
  logic               w_enq;
  logic               w_deq;
  logic               w_empty;
  logic               w_full;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_new_entry;

  assign imem_addr = r_pc;

  // A redirect cycle neither presents the head nor accepts a new fetch;
  // the first instruction from the new PC is fetched on the next cycle.
  assign out_valid   = ~w_empty & ~redirect_valid;
  assign w_deq       = out_valid & out_ready;
  assign w_enq       = ~redirect_valid & (~w_full | w_deq);
  assign w_new_entry = {r_pc, imem_data};

  assign out_pc    = w_head[INSTR_W +: ADDR_W];
  assign out_instr = w_head[INSTR_W-1:0];
  assign full      = w_full;

  // PC advances only when the current fetch is captured; a stall holds it
  // so the same address is re-read once space opens up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_enq) begin
      r_pc <= r_pc + ADDR_W'(PC_STEP);
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_enq   (w_enq),
    .i_deq   (w_deq),
    .i_flush (redirect_valid),
    .i_data  (w_new_entry),
    .o_data  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
